// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pc_sel/fwd encodings and scoreboard entry type for pipe_ctrl (CPU_FWD_EN selects forwarding)
package cpu_pkg;
  localparam int SB_AW = 8;
  typedef enum logic [1:0] {
    PC_NPC = 2'd0,
    PC_BR  = 2'd1,
    PC_EXC = 2'd2,
    PC_EPC = 2'd3
  } pc_sel_e;
  typedef logic [2:0] fwd_t;
  localparam fwd_t FWD_RF = 3'd0;
  // wa is sized for the widest supported register file; narrower addresses are zero-extended
  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] wa;
    logic             is_load;
  } sb_entry_t;
  function automatic fwd_t fwd_entry(input int k);
    return fwd_t'(k + 1);
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage decode inputs and hazard/PC control outputs of pipe_ctrl
interface pipe_ctrl_if #(parameter int REG_AW = 5);
  import cpu_pkg::*;
  logic [REG_AW-1:0] id_rs, id_rt, id_wa;
  logic              id_use_rs, id_use_rt, id_wen, id_is_load, id_is_md, id_reads_hilo, id_branch;
  logic              exc_req, eret;
  logic              stall, flush_if, flush_id, md_busy;
  pc_sel_e           pc_sel;
  fwd_t              fwd_a, fwd_b;
  modport master (
    output id_rs, id_rt, id_wa, id_use_rs, id_use_rt, id_wen, id_is_load, id_is_md,
           id_reads_hilo, id_branch, exc_req, eret,
    input  stall, flush_if, flush_id, md_busy, pc_sel, fwd_a, fwd_b
  );
  modport slave (
    input  id_rs, id_rt, id_wa, id_use_rs, id_use_rt, id_wen, id_is_load, id_is_md,
           id_reads_hilo, id_branch, exc_req, eret,
    output stall, flush_if, flush_id, md_busy, pc_sel, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: EXE..WB destination shift register with per-entry source match vectors
module pipe_scoreboard
  import cpu_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  sb_entry_t         id_entry,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic [STAGES-1:0] match_a,
  output logic [STAGES-1:0] match_b,
  output logic              load_hit
);
  sb_entry_t [STAGES-1:0] sb;
  always_ff @(posedge clk)
    if (rst) sb <= '0;
    else sb <= {sb[STAGES-2:0], advance ? id_entry : sb_entry_t'('0)};
  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_match
      assign match_a[i] = use_rs && rs != '0 && sb[i].valid && sb[i].wa == SB_AW'(rs);
      assign match_b[i] = use_rt && rt != '0 && sb[i].valid && sb[i].wa == SB_AW'(rt);
    end
  endgenerate
  assign load_hit = sb[0].is_load && (match_a[0] || match_b[0]);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, flush, PC-select and forwarding control for an in-order pipeline.
// CPU_FWD_EN defined enables operand forwarding; otherwise RAW hazards stall until WB.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT - 1);
  localparam logic [STAGES-1:0] NOT_WB = {1'b0, {(STAGES-1){1'b1}}};
  logic [CW-1:0]     md_cnt;
  logic [STAGES-1:0] match_a, match_b;
  logic              load_hit, hazard, md_stall, advance;
  sb_entry_t         id_entry;
  assign id_entry = '{valid: bus.id_wen && bus.id_wa != '0, wa: SB_AW'(bus.id_wa), is_load: bus.id_is_load};
  assign advance = !bus.stall && !bus.flush_id;
  pipe_scoreboard #(.STAGES(STAGES), .REG_AW(REG_AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .advance(advance),
    .id_entry(id_entry),
    .rs(bus.id_rs),
    .rt(bus.id_rt),
    .use_rs(bus.id_use_rs),
    .use_rt(bus.id_use_rt),
    .match_a(match_a),
    .match_b(match_b),
    .load_hit(load_hit)
  );
  // exceptions never touch the counter: a running mult/div keeps its occupancy
  always_ff @(posedge clk)
    if (rst) md_cnt <= '0;
    else if (advance && bus.id_is_md) md_cnt <= MD_INIT;
    else if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
  always_comb begin
`ifdef CPU_FWD_EN
    hazard = load_hit;
`else
    hazard = load_hit || |((match_a | match_b) & NOT_WB);
`endif
    md_stall = md_cnt != '0 && (bus.id_is_md || bus.id_reads_hilo);
    bus.md_busy = !rst && md_cnt != '0;
    bus.stall = 1'b0;
    bus.flush_if = 1'b0;
    bus.flush_id = 1'b0;
    bus.pc_sel = PC_NPC;
    if (!rst) begin
      if (bus.exc_req) begin
        bus.pc_sel = PC_EXC;
        bus.flush_if = 1'b1;
        bus.flush_id = 1'b1;
      end else if (bus.eret) begin
        bus.pc_sel = PC_EPC;
        bus.flush_if = 1'b1;
        bus.flush_id = 1'b1;
      end else if (hazard || md_stall) begin
        bus.stall = 1'b1;
        bus.flush_id = 1'b1;
      end else if (bus.id_branch) begin
        bus.pc_sel = PC_BR;
        bus.flush_if = 1'b1;
      end
    end
  end
  // scanning oldest to youngest lets the youngest match win
  always_comb begin
    bus.fwd_a = FWD_RF;
    bus.fwd_b = FWD_RF;
`ifdef CPU_FWD_EN
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (!rst && match_a[k]) bus.fwd_a = fwd_entry(k);
      if (!rst && match_b[k]) bus.fwd_b = fwd_entry(k);
    end
`endif
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (covers both CPU_FWD_EN builds)
module tb_pipe_ctrl;
  import cpu_pkg::*;
  localparam int STAGES = 3;
  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [11:0] obs;
  always #5 clk = ~clk;
  pipe_ctrl_if #(.REG_AW(REG_AW)) bus ();
  pipe_ctrl #(.STAGES(STAGES), .REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  assign obs = {bus.stall, bus.flush_if, bus.flush_id, bus.pc_sel, bus.fwd_a, bus.fwd_b, bus.md_busy};

  function automatic logic [11:0] ctl(input logic st, fi, fd, input logic [1:0] pc,
                                      input logic [2:0] fa, fb, input logic mb);
    return {st, fi, fd, pc, fa, fb, mb};
  endfunction

  task automatic issue(input logic [4:0] rs, rt, input logic urs, urt,
                       input logic [4:0] wa, input logic wen, ld, md, hilo);
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_use_rs = urs;
    bus.id_use_rt = urt;
    bus.id_wa = wa;
    bus.id_wen = wen;
    bus.id_is_load = ld;
    bus.id_is_md = md;
    bus.id_reads_hilo = hilo;
    bus.id_branch = 1'b0;
    bus.exc_req = 1'b0;
    bus.eret = 1'b0;
    #1;
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (STAGES + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue(3, 3, 1, 1, 3, 1, 1, 1, 1);
    bus.exc_req = 1'b1;
    bus.id_branch = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL reset_outputs got=%h exp=000", obs);
      failures++;
    end
    tick();
    tick();
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL reset_held got=%h exp=000", obs);
      failures++;
    end
    rst = 1'b0;
    issue(3, 4, 1, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL post_reset_empty got=%h exp=000", obs);
      failures++;
    end
  endtask

  task automatic test_raw();
    int n;
    drain();
`ifdef CPU_FWD_EN
    issue(1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    issue(3, 3, 1, 1, 6, 1, 0, 0, 0);
    checks++;
    if (obs !== ctl(0, 0, 0, 0, 1, 1, 0)) begin
      $display("FAIL alu_fwd got=%h exp=%h", obs, ctl(0, 0, 0, 0, 1, 1, 0));
      failures++;
    end
    drain();
    issue(1, 0, 1, 0, 3, 1, 1, 0, 0);
    tick();
    issue(3, 5, 1, 1, 4, 1, 0, 0, 0);
    checks++;
    if (obs[11:7] !== 5'b10100) begin
      $display("FAIL lu_stall got=%b exp=10100", obs[11:7]);
      failures++;
    end
    tick();
    checks++;
    if (obs !== ctl(0, 0, 0, 0, 2, 0, 0)) begin
      $display("FAIL lu_fwd_mem got=%h exp=%h", obs, ctl(0, 0, 0, 0, 2, 0, 0));
      failures++;
    end
`else
    issue(1, 2, 1, 1, 3, 1, 0, 0, 0);
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL raw_producer got=%h exp=000", obs);
      failures++;
    end
    tick();
    issue(3, 5, 1, 1, 4, 1, 0, 0, 0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (!bus.stall) break;
      n++;
      checks++;
      if (obs !== ctl(1, 0, 1, 0, 0, 0, 0)) begin
        $display("FAIL raw_stall_ctl got=%h exp=%h", obs, ctl(1, 0, 1, 0, 0, 0, 0));
        failures++;
      end
      tick();
    end
    checks++;
    if (n !== 2) begin
      $display("FAIL raw_stall_len got=%0d exp=2", n);
      failures++;
    end
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL raw_release got=%h exp=000", obs);
      failures++;
    end
`endif
  endtask

  task automatic test_md();
    int sc, bc;
    drain();
    issue(1, 2, 1, 1, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL md_issue got=%h exp=000", obs);
      failures++;
    end
    tick();
    issue(0, 0, 0, 0, 2, 1, 0, 0, 1);
    sc = 0;
    bc = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.md_busy) bc++;
      if (!bus.stall) break;
      sc++;
      checks++;
      if (obs !== ctl(1, 0, 1, 0, 0, 0, 1)) begin
        $display("FAIL md_stall_ctl got=%h exp=%h", obs, ctl(1, 0, 1, 0, 0, 0, 1));
        failures++;
      end
      tick();
    end
    checks++;
    if (sc !== 3) begin
      $display("FAIL mflo_stall_len got=%0d exp=3", sc);
      failures++;
    end
    checks++;
    if (bc !== 3) begin
      $display("FAIL md_busy_len got=%0d exp=3", bc);
      failures++;
    end
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL md_release got=%h exp=000", obs);
      failures++;
    end
  endtask

  task automatic test_exc_md();
    drain();
    issue(1, 2, 1, 1, 0, 0, 0, 1, 0);
    tick();
    idle();
    bus.exc_req = 1'b1;
    #1;
    checks++;
    if (obs !== ctl(0, 1, 1, 2, 0, 0, 1)) begin
      $display("FAIL exc_md_ctl got=%h exp=%h", obs, ctl(0, 1, 1, 2, 0, 0, 1));
      failures++;
    end
    tick();
    bus.exc_req = 1'b0;
    #1;
    checks++;
    if (bus.md_busy !== 1'b1) begin
      $display("FAIL exc_keeps_md got=%b exp=1", bus.md_busy);
      failures++;
    end
  endtask

  task automatic test_priority();
    drain();
    issue(1, 0, 1, 0, 3, 1, 1, 0, 0);
    tick();
    issue(3, 5, 1, 1, 4, 1, 0, 0, 0);
    bus.exc_req = 1'b1;
    bus.eret = 1'b1;
    bus.id_branch = 1'b1;
    #1;
    checks++;
    if (obs[11:7] !== 5'b01110) begin
      $display("FAIL prio_exc got=%b exp=01110", obs[11:7]);
      failures++;
    end
    bus.exc_req = 1'b0;
    #1;
    checks++;
    if (obs[11:7] !== 5'b01111) begin
      $display("FAIL prio_eret got=%b exp=01111", obs[11:7]);
      failures++;
    end
    bus.eret = 1'b0;
    #1;
    checks++;
    if (obs[11:7] !== 5'b10100) begin
      $display("FAIL prio_stall_branch got=%b exp=10100", obs[11:7]);
      failures++;
    end
    drain();
    bus.id_branch = 1'b1;
    #1;
    checks++;
    if (obs !== ctl(0, 1, 0, 1, 0, 0, 0)) begin
      $display("FAIL branch_taken got=%h exp=%h", obs, ctl(0, 1, 0, 1, 0, 0, 0));
      failures++;
    end
  endtask

  task automatic test_zero();
    drain();
    issue(1, 2, 1, 1, 0, 1, 1, 0, 0);
    tick();
    issue(0, 0, 1, 1, 5, 1, 0, 0, 0);
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL zero_reg got=%h exp=000", obs);
      failures++;
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    issue(1, 0, 1, 0, 3, 1, 1, 0, 0);
    tick();
    issue(3, 0, 1, 0, 4, 1, 0, 0, 0);
    checks++;
    if (bus.stall !== 1'b1) begin
      $display("FAIL pre_reset_stall got=%b exp=1", bus.stall);
      failures++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL rst_during_stall got=%h exp=000", obs);
      failures++;
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      $display("FAIL post_rst_clear got=%h exp=000", obs);
      failures++;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw();
    test_md();
    test_exc_md();
    test_priority();
    test_zero();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
